// File: rtl/load_store_unit.sv
// Memory stage behind the ALU. It handles one instruction at a time and
// runs loads/stores over a req/gnt/rvalid port before writeback.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_is_load,
  input  logic        in_is_store,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_we,
  output logic        out_fault
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_t;

  state_t state, state_nxt;

  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        ld_q;
  logic        is_mem;
  logic        fault;
  logic        ld_bad;
  logic        st_bad;
  logic        mis;
  logic [3:0]  st_strb;
  logic [31:0] st_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign is_mem    = in_is_load | in_is_store;
  assign in_ready  = (state == IDLE) && !rst;
  assign mem_req   = (state == REQ);
  assign out_valid = (state == RESP);

  always_comb begin
    ld_bad = in_is_load &&
             (in_funct3 == 3'b011 ||
              in_funct3[2:1] == 2'b11);
    st_bad = in_is_store &&
             !(in_funct3 == 3'b000 ||
               in_funct3 == 3'b001 ||
               in_funct3 == 3'b010);
    mis = is_mem &&
          ((in_funct3[1:0] == 2'b01 &&
            in_addr[0]) ||
           (in_funct3 == 3'b010 &&
            in_addr[1:0] != 2'b00));
    fault = ld_bad | st_bad | mis |
            (in_is_load & in_is_store);
  end

  always_comb begin
    st_strb = 4'b0001 << in_addr[1:0];
    st_data = {4{in_wdata[7:0]}};
    unique case (1'b1)
      in_funct3[1:0] == 2'b10: begin
        st_strb = 4'b1111;
        st_data = in_wdata;
      end
      in_funct3[1:0] == 2'b01: begin
        st_strb = 4'b0011 << {in_addr[1], 1'b0};
        st_data = {2{in_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane select by the captured byte offset, then extend.
  always_comb begin
    ld_byte = mem_rdata[{off_q, 3'b000} +: 8];
    ld_half = off_q[1] ? mem_rdata[31:16]
                       : mem_rdata[15:0];
    ld_data = mem_rdata;
    unique case (1'b1)
      f3_q[1:0] == 2'b00:
        ld_data = {{24{~f3_q[2] & ld_byte[7]}},
                   ld_byte};
      f3_q[1:0] == 2'b01:
        ld_data = {{16{~f3_q[2] & ld_half[15]}},
                   ld_half};
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (in_valid)
          state_nxt = (is_mem && !fault) ? REQ
                                         : RESP;
      REQ:
        if (mem_gnt)
          state_nxt = ld_q ? WAIT : RESP;
      WAIT:
        if (mem_rvalid)
          state_nxt = RESP;
      RESP:
        if (out_ready)
          state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f3_q      <= '0;
      off_q     <= '0;
      ld_q      <= 1'b0;
      out_data  <= '0;
      out_rd    <= '0;
      out_we    <= 1'b0;
      out_fault <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      unique case (state)
        IDLE:
          if (in_valid) begin
            f3_q      <= in_funct3;
            off_q     <= in_addr[1:0];
            ld_q      <= in_is_load;
            out_rd    <= in_rd;
            out_data  <= in_addr;
            out_fault <= fault;
            out_we    <= !is_mem && (in_rd != '0);
            if (is_mem && !fault) begin
              mem_we    <= in_is_store;
              mem_addr  <= {in_addr[31:2], 2'b00};
              mem_wdata <= st_data;
              mem_wstrb <= in_is_store ? st_strb
                                       : 4'b0000;
            end
          end
        WAIT:
          if (mem_rvalid) begin
            out_data <= ld_data;
            out_we   <= (out_rd != '0);
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: ALU pass-through, loads, stores,
// faults, backpressure and reset during an outstanding load.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_is_load;
  logic        in_is_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [4:0]  in_rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_we;
  logic        out_fault;

  int errors = 0;
  int checks = 0;

  load_store_unit dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_is_load(in_is_load),
    .in_is_store(in_is_store),
    .in_funct3(in_funct3),
    .in_addr(in_addr),
    .in_wdata(in_wdata),
    .in_rd(in_rd),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_rd(out_rd),
    .out_we(out_we),
    .out_fault(out_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ld,
                       input logic st,
                       input logic [2:0] f3,
                       input logic [31:0] a,
                       input logic [31:0] wd,
                       input logic [4:0] rd);
    in_is_load  = ld;
    in_is_store = st;
    in_funct3   = f3;
    in_addr     = a;
    in_wdata    = wd;
    in_rd       = rd;
    in_valid    = 1'b1;
    check("accept_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic load_txn(input string tag,
                          input logic [2:0] f3,
                          input logic [31:0] a,
                          input logic [4:0] rd,
                          input logic [31:0] rdata,
                          input logic [31:0] exp,
                          input logic exp_we);
    issue(1'b1, 1'b0, f3, a, 32'h0, rd);
    check({tag, "_req"}, 32'(mem_req), 1);
    check({tag, "_addr"}, mem_addr,
          {a[31:2], 2'b00});
    check({tag, "_strb"}, 32'(mem_wstrb), 0);
    check({tag, "_we"}, 32'(mem_we), 0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check({tag, "_wait_req"}, 32'(mem_req), 0);
    check({tag, "_wait_vld"}, 32'(out_valid), 0);
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    tick();
    mem_rvalid = 1'b0;
    check({tag, "_vld"}, 32'(out_valid), 1);
    check({tag, "_data"}, out_data, exp);
    check({tag, "_owe"}, 32'(out_we), 32'(exp_we));
    check({tag, "_rd"}, 32'(out_rd), 32'(rd));
    check({tag, "_flt"}, 32'(out_fault), 0);
    tick();
  endtask

  task automatic store_txn(input string tag,
                           input logic [2:0] f3,
                           input logic [31:0] a,
                           input logic [31:0] wd,
                           input int delay,
                           input logic [3:0] strb,
                           input logic [31:0] exp_wd);
    int req_cycles;
    req_cycles = 0;
    issue(1'b0, 1'b1, f3, a, wd, 5'd1);
    for (int i = 0; i <= delay; i++) begin
      if (mem_req) req_cycles++;
      check({tag, "_addr"}, mem_addr,
            {a[31:2], 2'b00});
      check({tag, "_strb"}, 32'(mem_wstrb),
            32'(strb));
      check({tag, "_wdata"}, mem_wdata, exp_wd);
      check({tag, "_we"}, 32'(mem_we), 1);
      mem_gnt = (i == delay);
      tick();
    end
    mem_gnt = 1'b0;
    check({tag, "_req_cycles"}, req_cycles,
          delay + 1);
    check({tag, "_vld"}, 32'(out_valid), 1);
    check({tag, "_owe"}, 32'(out_we), 0);
    check({tag, "_flt"}, 32'(out_fault), 0);
    check({tag, "_req_off"}, 32'(mem_req), 0);
    tick();
  endtask

  task automatic fault_txn(input string tag,
                           input logic ld,
                           input logic st,
                           input logic [2:0] f3,
                           input logic [31:0] a);
    issue(ld, st, f3, a, 32'h1234_5678, 5'd4);
    check({tag, "_req"}, 32'(mem_req), 0);
    check({tag, "_vld"}, 32'(out_valid), 1);
    check({tag, "_flt"}, 32'(out_fault), 1);
    check({tag, "_owe"}, 32'(out_we), 0);
    check({tag, "_data"}, out_data, a);
    tick();
    check({tag, "_req_after"}, 32'(mem_req), 0);
  endtask

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_is_load  = 1'b0;
    in_is_store = 1'b0;
    in_funct3   = 3'b000;
    in_addr     = '0;
    in_wdata    = '0;
    in_rd       = '0;
    mem_gnt     = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = '0;
    out_ready   = 1'b1;

    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 0);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_rd", 32'(out_rd), 0);
    check("rst_out_we", 32'(out_we), 0);
    check("rst_out_fault", 32'(out_fault), 0);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("idle_in_ready", 32'(in_ready), 1);

    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("idle_gnt_vld", 32'(out_valid), 0);
    check("idle_gnt_rdy", 32'(in_ready), 1);

    issue(1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0, 5'd5);
    check("alu_vld", 32'(out_valid), 1);
    check("alu_data", out_data, 32'h1234_5678);
    check("alu_we", 32'(out_we), 1);
    check("alu_flt", 32'(out_fault), 0);
    check("alu_rd", 32'(out_rd), 5);
    check("alu_req", 32'(mem_req), 0);
    check("alu_busy", 32'(in_ready), 0);
    tick();
    check("alu_back_idle", 32'(in_ready), 1);

    issue(1'b0, 1'b0, 3'b000, 32'h0000_0042, 32'h0, 5'd0);
    check("alu_x0_we", 32'(out_we), 0);
    tick();

    load_txn("lb", 3'b000, 32'h103, 5'd6,
             32'h80FF_0000, 32'hFFFF_FF80, 1'b1);
    load_txn("lbu", 3'b100, 32'h103, 5'd6,
             32'h80FF_0000, 32'h0000_0080, 1'b1);
    load_txn("lh", 3'b001, 32'h102, 5'd6,
             32'h80FF_0000, 32'hFFFF_80FF, 1'b1);
    load_txn("lhu", 3'b101, 32'h102, 5'd6,
             32'h80FF_0000, 32'h0000_80FF, 1'b1);
    load_txn("lb0", 3'b000, 32'h100, 5'd6,
             32'h1234_5678, 32'h0000_0078, 1'b1);
    load_txn("lw", 3'b010, 32'h104, 5'd8,
             32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
    load_txn("lb_x0", 3'b000, 32'h101, 5'd0,
             32'h0000_7F00, 32'h0000_007F, 1'b0);

    store_txn("sh", 3'b001, 32'h202, 32'h0000_BEEF,
              3, 4'b1100, 32'hBEEF_BEEF);
    store_txn("sb", 3'b000, 32'h301, 32'h1234_5678,
              0, 4'b0010, 32'h7878_7878);
    store_txn("sw", 3'b010, 32'h400, 32'hA5A5_1234,
              1, 4'b1111, 32'hA5A5_1234);

    fault_txn("lw_mis", 1'b1, 1'b0, 3'b010, 32'h101);
    fault_txn("st_f3", 1'b0, 1'b1, 3'b011, 32'h100);
    fault_txn("lh_mis", 1'b1, 1'b0, 3'b001, 32'h203);
    fault_txn("ld_f3", 1'b1, 1'b0, 3'b110, 32'h200);
    fault_txn("ld_st", 1'b1, 1'b1, 3'b000, 32'h200);

    out_ready = 1'b0;
    issue(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 5'd7);
    mem_gnt = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    tick();
    mem_rvalid  = 1'b0;
    in_is_load  = 1'b0;
    in_is_store = 1'b0;
    in_funct3   = 3'b000;
    in_addr     = 32'h0000_0055;
    in_rd       = 5'd9;
    in_valid    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_vld", 32'(out_valid), 1);
      check("bp_data", out_data, 32'hCAFE_F00D);
      check("bp_rd", 32'(out_rd), 7);
      check("bp_we", 32'(out_we), 1);
      check("bp_busy", 32'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    check("bp_last_vld", 32'(out_valid), 1);
    tick();
    check("bp_idle_vld", 32'(out_valid), 0);
    check("bp_idle_rdy", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    check("bp_next_vld", 32'(out_valid), 1);
    check("bp_next_data", out_data, 32'h0000_0055);
    check("bp_next_rd", 32'(out_rd), 9);
    tick();

    issue(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 5'd3);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    rst = 1'b1;
    #1;
    check("rw_rst_rdy", 32'(in_ready), 0);
    tick();
    rst = 1'b0;
    #1;
    check("rw_req", 32'(mem_req), 0);
    check("rw_vld", 32'(out_valid), 0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1111_2222;
    tick();
    mem_rvalid = 1'b0;
    check("rw_late_vld", 32'(out_valid), 0);
    check("rw_late_rdy", 32'(in_ready), 1);
    check("rw_late_data", out_data, 0);
    tick();
    check("rw_still_idle", 32'(out_valid), 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
